// File: rtl/alu_hs_if.sv
// alu_hs_if: bundle of the operand-issue and result-delivery handshakes of alu_hs.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid & ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0; ready may depend combinationally on the consumer state.
//
// Parameters
//   WIDTH  operand/result width
//   TAG_W  width of the opaque tag
// Signals
//   in_valid/in_ready, in_a, in_b, in_op, in_sra, in_tag   : issue channel
//   out_valid/out_ready, out_result, out_tag,
//   out_zero, out_carry, out_ovf, out_err                  : result channel
// Modports
//   slave  : the ALU's view (consumes issue channel, produces result channel)
//   master : the environment's view (issuer + result consumer)
interface alu_hs_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_sra;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_sra, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag,
               out_zero, out_carry, out_ovf, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_sra, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag,
               out_zero, out_carry, out_ovf, out_err
    );
endinterface

// File: rtl/alu_hs.sv
// alu_hs: registered ALU with valid/ready handshakes on issue and result sides.
//
// Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL/SRA (in_sra selects), 7 MUL.
// Ops 0-6 complete in one cycle (accept at edge N, result valid after edge N),
// sustaining one op per cycle while the consumer keeps out_ready high.
//
// Build option: macro ALU_MUL_EN
//   defined   : op 7 is an iterative shift-add multiply (one multiplier bit per
//               cycle); FSM IDLE -> BUSY -> (HOLD) -> IDLE.
//   undefined : no multiplier and no FSM beyond IDLE; op 7 completes in one
//               cycle with result 0, zero=1, err=1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        alu_hs_if.slave (issue + result channels, see interface file)
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 HOLD)
module alu_hs #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_hs_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRX = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t state;

    logic slot_free;     // result register may be (re)loaded this edge
    logic accept;        // issue-side transfer this edge
    logic load_single;   // single-cycle op completes this edge
    logic mul_load;      // multiply result completes this edge

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_err;

    assign add_full = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    // a + ~b + 1: carry-out is 1 exactly when a >= b (unsigned).
    assign sub_full = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + (WIDTH+1)'(1);
    assign shamt    = bus.in_b[SHAMT_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (bus.in_a[MSB] == bus.in_b[MSB]) &&
                            (add_full[MSB] != bus.in_a[MSB]);
            end
            OP_SUB: begin
                alu_res   = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (bus.in_a[MSB] != bus.in_b[MSB]) &&
                            (sub_full[MSB] != bus.in_a[MSB]);
            end
            OP_AND: alu_res = bus.in_a & bus.in_b;
            OP_OR:  alu_res = bus.in_a | bus.in_b;
            OP_XOR: alu_res = bus.in_a ^ bus.in_b;
            OP_SLL: alu_res = bus.in_a << shamt;
            OP_SRX: begin
                if (bus.in_sra) begin
                    alu_res = $unsigned($signed(bus.in_a) >>> shamt);
                end else begin
                    alu_res = bus.in_a >> shamt;
                end
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                // Handled by the iterative multiplier; never loaded from here.
                alu_res = '0;
`else
                alu_err = 1'b1;
`endif
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier + FSM
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_next;
    logic             is_mul_op;
    logic             mul_done;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [TAG_W-1:0] mul_tag;
    logic [CNT_W-1:0] mul_cnt;

    assign is_mul_op = (bus.in_op == OP_MUL);
    // All WIDTH multiplier bits consumed; the cycle with mul_done set is the
    // completion cycle, which gives the WIDTH+1 edge latency.
    assign mul_done  = (mul_cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul_op) state_next = ST_BUSY;
            ST_BUSY: if (mul_done) state_next = slot_free ? ST_IDLE : ST_HOLD;
            ST_HOLD: if (slot_free) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift-add: the multiplicand walks left, the multiplier walks right and
    // its LSB decides whether the current partial product is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_tag    <= '0;
            mul_cnt    <= '0;
        end else if (accept && is_mul_op) begin
            mul_acc    <= '0;
            mul_mcand  <= bus.in_a;
            mul_mplier <= bus.in_b;
            mul_tag    <= bus.in_tag;
            mul_cnt    <= '0;
        end else if (state == ST_BUSY && !mul_done) begin
            if (mul_mplier[0]) begin
                mul_acc <= mul_acc + mul_mcand;
            end
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CNT_W'(1);
        end
    end

    assign load_single = accept && !is_mul_op;
`else
    always_comb state = ST_IDLE;

    assign load_single = accept;
`endif

    // FSM outputs
    always_comb begin
        bus.in_ready = rst_n && (state == ST_IDLE) && slot_free;
        mul_load     = 1'b0;
`ifdef ALU_MUL_EN
        mul_load     = (((state == ST_BUSY) && mul_done) || (state == ST_HOLD)) && slot_free;
`endif
        dbg_state    = state;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic [TAG_W-1:0] ld_tag;
    logic             ld_carry;
    logic             ld_ovf;
    logic             ld_err;

    // mul_load only occurs outside IDLE and accept only inside it, so the two
    // load sources never collide.
    always_comb begin
        ld       = load_single || mul_load;
        ld_res   = alu_res;
        ld_tag   = bus.in_tag;
        ld_carry = alu_carry;
        ld_ovf   = alu_ovf;
        ld_err   = alu_err;
`ifdef ALU_MUL_EN
        if (mul_load) begin
            ld_res   = mul_acc;
            ld_tag   = mul_tag;
            ld_carry = 1'b0;
            ld_ovf   = 1'b0;
            ld_err   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_tag    <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_carry  <= 1'b0;
            bus.out_ovf    <= 1'b0;
            bus.out_err    <= 1'b0;
        end else if (ld) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= ld_res;
            bus.out_tag    <= ld_tag;
            bus.out_zero   <= (ld_res == '0);
            bus.out_carry  <= ld_carry;
            bus.out_ovf    <= ld_ovf;
            bus.out_err    <= ld_err;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule
